// File: rtl/riscv_nn_instr_encoder.sv
// Encodes symbolic RV32I commands into machine words and queues them, tagged
// with a running PC, for the fetch-side stimulus port. Illegal commands are dropped and counted.
module riscv_nn_instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [4:0]  cmd_op_i,
  input  logic [4:0]  cmd_rd_i,
  input  logic [4:0]  cmd_rs1_i,
  input  logic [4:0]  cmd_rs2_i,
  input  logic [12:0] cmd_imm_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_data_o,
  output logic [31:0] instr_pc_o,
  output logic        err_o,
  output logic [7:0]  err_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {FMT_I, FMT_SH, FMT_R, FMT_B} fmt_e;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  fmt_e        fmt;
  logic [2:0]  f3;
  logic        alt;
  logic        op_ok;
  logic        legal;
  logic [31:0] word;

  // Op decode: instruction format, funct3 and the funct7 "alternate" bit.
  always_comb begin
    fmt   = FMT_I;
    f3    = 3'b000;
    alt   = 1'b0;
    op_ok = 1'b1;
    case (cmd_op_i)
      5'd0:  begin fmt = FMT_I;  f3 = 3'b000; end
      5'd1:  begin fmt = FMT_I;  f3 = 3'b010; end
      5'd2:  begin fmt = FMT_I;  f3 = 3'b011; end
      5'd3:  begin fmt = FMT_I;  f3 = 3'b100; end
      5'd4:  begin fmt = FMT_I;  f3 = 3'b110; end
      5'd5:  begin fmt = FMT_I;  f3 = 3'b111; end
      5'd6:  begin fmt = FMT_SH; f3 = 3'b001; end
      5'd7:  begin fmt = FMT_SH; f3 = 3'b101; end
      5'd8:  begin fmt = FMT_SH; f3 = 3'b101; alt = 1'b1; end
      5'd9:  begin fmt = FMT_R;  f3 = 3'b000; end
      5'd10: begin fmt = FMT_R;  f3 = 3'b000; alt = 1'b1; end
      5'd11: begin fmt = FMT_R;  f3 = 3'b001; end
      5'd12: begin fmt = FMT_R;  f3 = 3'b010; end
      5'd13: begin fmt = FMT_R;  f3 = 3'b011; end
      5'd14: begin fmt = FMT_R;  f3 = 3'b100; end
      5'd15: begin fmt = FMT_R;  f3 = 3'b101; end
      5'd16: begin fmt = FMT_R;  f3 = 3'b101; alt = 1'b1; end
      5'd17: begin fmt = FMT_R;  f3 = 3'b110; end
      5'd18: begin fmt = FMT_R;  f3 = 3'b111; end
      5'd19: begin fmt = FMT_B;  f3 = 3'b000; end
      5'd20: begin fmt = FMT_B;  f3 = 3'b001; end
      5'd21: begin fmt = FMT_B;  f3 = 3'b100; end
      5'd22: begin fmt = FMT_B;  f3 = 3'b101; end
      5'd23: begin fmt = FMT_B;  f3 = 3'b110; end
      5'd24: begin fmt = FMT_B;  f3 = 3'b111; end
      default: op_ok = 1'b0;
    endcase
  end

  // Shift amounts above 31 and odd branch offsets cannot be encoded.
  assign legal = op_ok
               & ~((fmt == FMT_SH) & (|cmd_imm_i[11:5]))
               & ~((fmt == FMT_B) & cmd_imm_i[0]);

  always_comb begin
    case (fmt)
      FMT_I:   word = {cmd_imm_i[11:0], cmd_rs1_i, f3, cmd_rd_i, 7'b0010011};
      FMT_SH:  word = {1'b0, alt, 5'b0, cmd_imm_i[4:0], cmd_rs1_i, f3, cmd_rd_i, 7'b0010011};
      FMT_R:   word = {1'b0, alt, 5'b0, cmd_rs2_i, cmd_rs1_i, f3, cmd_rd_i, 7'b0110011};
      default: word = {cmd_imm_i[12], cmd_imm_i[10:5], cmd_rs2_i, cmd_rs1_i, f3,
                       cmd_imm_i[4:1], cmd_imm_i[11], 7'b1100011};
    endcase
  end

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0]   pc_q, pc_d;
  logic          err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic accept;
  logic push;
  logic pop;

  // Ready looks only at the count, so a full FIFO never accepts even while popping.
  assign cmd_ready_o   = (cnt_q != FULL) & ~flush_i;
  assign accept        = cmd_valid_i & cmd_ready_o;
  assign push          = accept & legal;
  assign pop           = (cnt_q != '0) & instr_ready_i & ~flush_i;
  assign instr_valid_o = (cnt_q != '0);
  assign instr_data_o  = mem_q[rd_ptr_q].data;
  assign instr_pc_o    = mem_q[rd_ptr_q].pc;
  assign err_o         = err_q;
  assign err_cnt_o     = err_cnt_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{data: word, pc: pc_q};
        wr_ptr_d        = wr_ptr_q + AW'(1);
        pc_d            = pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    err_d     = accept & ~legal;
    err_cnt_d = err_cnt_q;
    if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '{data: 32'h0, pc: BOOT_ADDR};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      pc_q      <= BOOT_ADDR;
      err_q     <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule
